// File: rtl/fsmc_page_buffer_pkg.sv
// Shared types and defaults for the FSMC page buffer.
// Word width, page depth and page-engine state codes.
package fsmc_page_buffer_pkg;

  localparam int PB_FSMC_WIDTH  = 16;
  localparam int PB_PAGE_ADDR_W = 9;
  localparam int PB_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    PB_IDLE  = 2'd0,
    PB_FILL  = 2'd1,
    PB_DRAIN = 2'd2
  } pb_state_e;

endpackage

// File: rtl/fsmc_sync.sv
// Multi-flop 1-bit synchroniser for FSMC control strobes.
// Reset value is a parameter so idle-high strobes do not fake an edge.
module fsmc_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fsmc_page_buffer.sv
// FSMC page buffer: captures MCU write pages and streams them out,
// and serves MCU page reads from a read-page RAM filled by FPGA logic.
module fsmc_page_buffer
  import fsmc_page_buffer_pkg::*;
#(
  parameter int FSMC_WIDTH  = PB_FSMC_WIDTH,
  parameter int PAGE_ADDR_W = PB_PAGE_ADDR_W,
  parameter int SYNC_STAGES = PB_SYNC_STAGES
) (
  input  logic                  CLK,
  input  logic                  NRESET,
  input  logic                  NWE,
  input  logic                  RESET_FSMC,
  input  logic                  READ_WRITE,
  input  logic [15:0]           COLUMN_ADDR,
  input  logic [15:0]           ROW_ADDR,
  input  logic [FSMC_WIDTH-1:0] OUT_DATA,
  output logic [FSMC_WIDTH-1:0] IN_DATA,
  output logic [FSMC_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  TX_LAST,
  output logic [15:0]           TX_ROW,
  input  logic [FSMC_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  input  logic                  RX_LAST,
  output logic                  PAGE_BUSY,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << PAGE_ADDR_W;

  typedef logic [PAGE_ADDR_W:0]   cnt_t;
  typedef logic [PAGE_ADDR_W-1:0] adr_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam adr_t ADR_ONE = adr_t'(1);

  logic nwe_s, rw_s, rst_s;

  fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nwe (
    .clk_i (CLK), .rst_ni(NRESET), .d_i(NWE), .q_o(nwe_s)
  );
  fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
    .clk_i (CLK), .rst_ni(NRESET), .d_i(READ_WRITE), .q_o(rw_s)
  );
  fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst (
    .clk_i (CLK), .rst_ni(NRESET), .d_i(RESET_FSMC), .q_o(rst_s)
  );

  pb_state_e state_q, state_d;
  logic nwe_prev_q, rw_prev_q;
  cnt_t wr_cnt_q, wr_cnt_d;
  cnt_t rd_ptr_q, rd_ptr_d;
  adr_t rx_ptr_q, rx_ptr_d;
  logic tx_valid_q, tx_valid_d;
  logic tx_last_q, tx_last_d;
  logic [15:0] tx_row_q, tx_row_d;
  logic ovf_q, ovf_d;
  logic rx_rdy_q;
  logic [FSMC_WIDTH-1:0] in_data_q, wr_rdata_q;
  logic [FSMC_WIDTH-1:0] wr_ram [DEPTH];
  logic [FSMC_WIDTH-1:0] rd_ram [DEPTH];

  logic nwe_rise, rw_rise, cap, drop, wr_en, rd_issue, rx_fire;
  adr_t idx;
  logic unused_col;

  assign unused_col = ^COLUMN_ADDR[15:PAGE_ADDR_W];

  assign nwe_rise = nwe_s & ~nwe_prev_q;
  assign rw_rise  = rw_s & ~rw_prev_q;
  // Decoder has already post-incremented the column on the strobe
  assign idx      = COLUMN_ADDR[PAGE_ADDR_W-1:0] - ADR_ONE;
  assign cap      = nwe_rise & ~rw_s & ~rst_s;
  assign drop     = cap & ((state_q == PB_DRAIN) |
                    (wr_cnt_q[PAGE_ADDR_W] & ({1'b0, idx} >= wr_cnt_q)));
  assign wr_en    = cap & ~drop;
  assign rx_fire  = RX_VALID & RX_READY;

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_row_d   = tx_row_q;
    ovf_d      = ovf_q;
    rd_issue   = 1'b0;
    unique case (state_q)
      PB_IDLE: begin
        if (wr_en) state_d = PB_FILL;
      end
      PB_FILL: begin
        if (rw_rise && wr_cnt_q != '0) begin
          state_d  = PB_DRAIN;
          tx_row_d = ROW_ADDR;
          rd_ptr_d = '0;
        end
      end
      PB_DRAIN: begin
        if (tx_valid_q && TX_READY) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          if (tx_last_q) begin
            state_d  = PB_IDLE;
            wr_cnt_d = '0;
          end
        end
        // Prefetch next word whenever the output slot is free or freeing
        if ((!tx_valid_q || TX_READY) && rd_ptr_q < wr_cnt_q) begin
          rd_issue   = 1'b1;
          tx_valid_d = 1'b1;
          tx_last_d  = (rd_ptr_q == wr_cnt_q - CNT_ONE);
          rd_ptr_d   = rd_ptr_q + CNT_ONE;
        end
      end
      default: state_d = PB_IDLE;
    endcase
    if (wr_en && {1'b0, idx} >= wr_cnt_q) begin
      wr_cnt_d = {1'b0, idx} + CNT_ONE;
    end
    if (drop) ovf_d = 1'b1;
    if (rst_s) begin
      state_d    = PB_IDLE;
      wr_cnt_d   = '0;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      ovf_d      = 1'b0;
      rd_issue   = 1'b0;
    end
  end

  always_comb begin
    rx_ptr_d = rx_ptr_q;
    if (rst_s) begin
      rx_ptr_d = '0;
    end else if (rx_fire) begin
      rx_ptr_d = RX_LAST ? '0 : rx_ptr_q + ADR_ONE;
    end
  end

  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      state_q    <= PB_IDLE;
      nwe_prev_q <= 1'b1;
      rw_prev_q  <= 1'b1;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      rx_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_row_q   <= '0;
      ovf_q      <= 1'b0;
      rx_rdy_q   <= 1'b0;
      in_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      nwe_prev_q <= nwe_s;
      rw_prev_q  <= rw_s;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_ptr_q   <= rx_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_row_q   <= tx_row_d;
      ovf_q      <= ovf_d;
      rx_rdy_q   <= 1'b1;
      in_data_q  <= rd_ram[COLUMN_ADDR[PAGE_ADDR_W-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) wr_ram[idx] <= OUT_DATA;
    if (rx_fire) rd_ram[rx_ptr_q] <= RX_DATA;
    if (rd_issue) wr_rdata_q <= wr_ram[rd_ptr_q[PAGE_ADDR_W-1:0]];
  end

  assign IN_DATA   = in_data_q;
  assign TX_DATA   = tx_valid_q ? wr_rdata_q : '0;
  assign TX_VALID  = tx_valid_q;
  assign TX_LAST   = tx_last_q;
  assign TX_ROW    = tx_row_q;
  assign RX_READY  = rx_rdy_q & ~rst_s;
  assign PAGE_BUSY = (state_q == PB_DRAIN);
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fsmc_page_buffer.sv
// Scoreboard bench for fsmc_page_buffer.
// Expected TX words are queued at page commit and popped per handshake.
module tb_fsmc_page_buffer;

  logic        CLK = 1'b0;
  logic        NRESET = 1'b0;
  logic        NWE = 1'b1;
  logic        RESET_FSMC = 1'b0;
  logic        READ_WRITE = 1'b1;
  logic [15:0] COLUMN_ADDR = '0;
  logic [15:0] ROW_ADDR = '0;
  logic [15:0] OUT_DATA = '0;
  logic [15:0] IN_DATA;
  logic [15:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        TX_LAST;
  logic [15:0] TX_ROW;
  logic [15:0] RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic        RX_LAST = 1'b0;
  logic        PAGE_BUSY;
  logic        OVERFLOW;

  fsmc_page_buffer dut (
    .CLK(CLK), .NRESET(NRESET), .NWE(NWE),
    .RESET_FSMC(RESET_FSMC), .READ_WRITE(READ_WRITE),
    .COLUMN_ADDR(COLUMN_ADDR), .ROW_ADDR(ROW_ADDR),
    .OUT_DATA(OUT_DATA), .IN_DATA(IN_DATA),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_LAST(TX_LAST),
    .TX_ROW(TX_ROW), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .RX_LAST(RX_LAST), .PAGE_BUSY(PAGE_BUSY),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n_tx = 0;
  int cyc = 0;
  int rdy_mode = 2;
  logic [16:0] exp_q[$];
  logic [15:0] exp_row;
  logic [15:0] mdl_mem [512];
  int mdl_cnt = 0;
  logic stall_pend = 1'b0;
  logic [16:0] stall_word;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    case (rdy_mode)
      0: TX_READY = 1'b1;
      1: TX_READY = (cyc % 3 == 0);
      default: TX_READY = 1'b0;
    endcase
  end

  always @(negedge CLK) begin
    if (stall_pend && TX_VALID && NRESET)
      check("tx_stable", {15'd0, TX_LAST, TX_DATA}, {15'd0, stall_word});
    stall_pend = 1'b0;
    if (TX_VALID && NRESET) begin
      if (TX_READY) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          check("tx_extra", 32'd1, 32'd0);
        end else begin
          check("tx_word", {15'd0, TX_LAST, TX_DATA},
                {15'd0, exp_q.pop_front()});
          check("tx_row", {16'd0, TX_ROW}, {16'd0, exp_row});
        end
      end else begin
        stall_pend = 1'b1;
        stall_word = {TX_LAST, TX_DATA};
      end
    end
  end

  task automatic nwe_pulse(input logic [15:0] col,
                           input logic [15:0] dat,
                           input bit model);
    int idx;
    COLUMN_ADDR = col;
    OUT_DATA = dat;
    NWE = 1'b0;
    tick(4);
    NWE = 1'b1;
    tick(4);
    if (model) begin
      idx = (int'(col) - 1) % 512;
      if (idx < 0) idx += 512;
      mdl_mem[idx] = dat;
      if (idx + 1 > mdl_cnt) mdl_cnt = idx + 1;
    end
  endtask

  task automatic commit(input logic [15:0] row);
    for (int i = 0; i < mdl_cnt; i++)
      exp_q.push_back({(i == mdl_cnt - 1), mdl_mem[i]});
    mdl_cnt = 0;
    exp_row = row;
    ROW_ADDR = row;
    READ_WRITE = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    tick(6);
    while ((exp_q.size() != 0 || PAGE_BUSY) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic rx_send(input logic [15:0] d, input logic last);
    RX_DATA = d;
    RX_LAST = last;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    RX_LAST = 1'b0;
  endtask

  task automatic write_page(input logic [15:0] base);
    READ_WRITE = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++)
      nwe_pulse(16'(i + 1), base + 16'(i), 1'b1);
  endtask

  initial begin
    int t0;
    #1;
    check("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
    check("rst_in_data", {16'd0, IN_DATA}, 32'd0);
    check("rst_rx_ready", {31'd0, RX_READY}, 32'd0);
    check("rst_busy", {31'd0, PAGE_BUSY}, 32'd0);
    check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    tick(3);
    NRESET = 1'b1;
    tick(3);
    check("rx_ready_up", {31'd0, RX_READY}, 32'd1);

    rdy_mode = 0;
    write_page(16'h00A0);
    commit(16'h0012);
    wait_drain(200);
    check("p2_busy", {31'd0, PAGE_BUSY}, 32'd0);

    rdy_mode = 1;
    write_page(16'h00A0);
    commit(16'h0012);
    wait_drain(300);

    rdy_mode = 2;
    write_page(16'h00C0);
    commit(16'h0034);
    tick(8);
    check("ovf_busy", {31'd0, PAGE_BUSY}, 32'd1);
    READ_WRITE = 1'b0;
    tick(4);
    nwe_pulse(16'd2, 16'hDEAD, 1'b0);
    check("ovf_set", {31'd0, OVERFLOW}, 32'd1);
    READ_WRITE = 1'b1;
    rdy_mode = 0;
    wait_drain(200);
    check("ovf_sticky", {31'd0, OVERFLOW}, 32'd1);
    RESET_FSMC = 1'b1;
    tick(4);
    check("rf_ovf", {31'd0, OVERFLOW}, 32'd0);
    check("rf_tx_valid", {31'd0, TX_VALID}, 32'd0);
    check("rf_rx_ready", {31'd0, RX_READY}, 32'd0);
    RESET_FSMC = 1'b0;
    tick(4);
    check("rf_rx_back", {31'd0, RX_READY}, 32'd1);

    for (int i = 0; i < 8; i++)
      rx_send(16'hB000 + 16'(i), i == 7);
    COLUMN_ADDR = 16'd5;
    tick();
    check("rd_col5", {16'd0, IN_DATA}, 32'h0000B005);
    COLUMN_ADDR = 16'h0207;
    tick();
    check("rd_upper_ign", {16'd0, IN_DATA}, 32'h0000B007);
    rx_send(16'hC000, 1'b0);
    COLUMN_ADDR = 16'd0;
    tick();
    check("rd_last_wrap", {16'd0, IN_DATA}, 32'h0000C000);
    COLUMN_ADDR = 16'd1;
    RX_DATA = 16'hD001;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    check("rd_old_data", {16'd0, IN_DATA}, 32'h0000B001);
    tick();
    check("rd_new_data", {16'd0, IN_DATA}, 32'h0000D001);

    rdy_mode = 1;
    READ_WRITE = 1'b0;
    tick(4);
    for (int i = 1; i <= 513; i++)
      nwe_pulse(16'(i), 16'h1000 + 16'(i), 1'b1);
    check("wrap_cnt_mdl", mdl_cnt, 32'd512);
    check("wrap_no_ovf", {31'd0, OVERFLOW}, 32'd0);
    t0 = n_tx;
    commit(16'h0077);
    wait_drain(3000);
    check("wrap_words", n_tx - t0, 32'd512);

    rdy_mode = 2;
    write_page(16'h00E0);
    commit(16'h0099);
    t0 = 0;
    while (!TX_VALID && t0 < 50) begin
      tick();
      t0++;
    end
    check("rd_tx_valid", {31'd0, TX_VALID}, 32'd1);
    NRESET = 1'b0;
    #1;
    check("ar_tx_valid", {31'd0, TX_VALID}, 32'd0);
    check("ar_tx_data", {16'd0, TX_DATA}, 32'd0);
    check("ar_tx_last", {31'd0, TX_LAST}, 32'd0);
    check("ar_tx_row", {16'd0, TX_ROW}, 32'd0);
    check("ar_busy", {31'd0, PAGE_BUSY}, 32'd0);
    check("ar_in_data", {16'd0, IN_DATA}, 32'd0);
    check("ar_rx_ready", {31'd0, RX_READY}, 32'd0);
    exp_q.delete();
    tick(2);
    NRESET = 1'b1;
    rdy_mode = 0;
    tick(10);
    check("post_tx_valid", {31'd0, TX_VALID}, 32'd0);
    check("post_busy", {31'd0, PAGE_BUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
